// File: rtl/crossover.sv
// rtl/crossover.sv - genetic-algorithm crossover stage (single-point, two-point, uniform, pass-through)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start_crossover       request, sampled only in IDLE
//   parent1, parent2      parent chromosomes (W bits)
//   crossover_mode        0 single-point, 1 two-point, 2 uniform, 3 pass-through
//   point_a, point_b      cut points (PW bits); point_b used by two-point only
//   uniform_mask          per-bit source select for uniform mode
//   crossover_rate        probability threshold; crossing happens when rand_byte < rate
//   rand_byte             random byte for the rate gate
//   child1, child2        registered offspring, held between completions
//   crossover_done        one-cycle pulse, three cycles after the accepted start
//   busy                  high in LOAD and CROSS
//   crossover_count       saturating count of operations that actually crossed
module crossover #(
  parameter int CHROMOSOME_WIDTH = 8,
  localparam int PW = $clog2(CHROMOSOME_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_crossover,
  input  logic [CHROMOSOME_WIDTH-1:0] parent1,
  input  logic [CHROMOSOME_WIDTH-1:0] parent2,
  input  logic [1:0]                  crossover_mode,
  input  logic [PW-1:0]               point_a,
  input  logic [PW-1:0]               point_b,
  input  logic [CHROMOSOME_WIDTH-1:0] uniform_mask,
  input  logic [7:0]                  crossover_rate,
  input  logic [7:0]                  rand_byte,
  output logic [CHROMOSOME_WIDTH-1:0] child1,
  output logic [CHROMOSOME_WIDTH-1:0] child2,
  output logic                        crossover_done,
  output logic                        busy,
  output logic [15:0]                 crossover_count
);

  localparam int W = CHROMOSOME_WIDTH;
  localparam logic [PW-1:0] MAX_PT = PW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CROSS = 2'd2
  } state_t;

  state_t state, state_next;

  // Operands captured at the accepted start.
  logic [W-1:0]  p1_q, p2_q, mask_q;
  logic [1:0]    mode_q;
  logic [PW-1:0] pa_q, pb_q;
  logic [7:0]    rate_q, rnd_q;

  // Values prepared in LOAD for use in CROSS.
  logic [PW-1:0] a_q, lo_q, hi_q;
  logic          en_q;

  logic [PW-1:0] pa_c, pb_c;
  logic [W-1:0]  sel;
  logic [W-1:0]  c1_next, c2_next;

  // When W is not a power of two the point field can encode positions past
  // the top bit; those are treated as the last bit position.
  function automatic logic [PW-1:0] clamp_pt(input logic [PW-1:0] p);
    return (int'(p) > W - 1) ? MAX_PT : p;
  endfunction

  assign pa_c = clamp_pt(pa_q);
  assign pb_c = clamp_pt(pb_q);

  // sel[i]=1 means child1 takes bit i from parent2 (and child2 from parent1).
  always_comb begin
    sel = '0;
    if (en_q) begin
      case (mode_q)
        2'd0:    sel = {W{1'b1}} << a_q;
        2'd1:    sel = ({W{1'b1}} << lo_q) & ~({W{1'b1}} << hi_q);
        2'd2:    sel = mask_q;
        default: sel = '0;
      endcase
    end
  end

  assign c1_next = (p1_q & ~sel) | (p2_q & sel);
  assign c2_next = (p2_q & ~sel) | (p1_q & sel);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_crossover) state_next = S_LOAD;
      S_LOAD:  state_next = S_CROSS;
      S_CROSS: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q            <= '0;
      p2_q            <= '0;
      mask_q          <= '0;
      mode_q          <= '0;
      pa_q            <= '0;
      pb_q            <= '0;
      rate_q          <= '0;
      rnd_q           <= '0;
      a_q             <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      en_q            <= 1'b0;
      child1          <= '0;
      child2          <= '0;
      crossover_done  <= 1'b0;
      crossover_count <= '0;
    end else begin
      crossover_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_crossover) begin
            p1_q   <= parent1;
            p2_q   <= parent2;
            mask_q <= uniform_mask;
            mode_q <= crossover_mode;
            pa_q   <= point_a;
            pb_q   <= point_b;
            rate_q <= crossover_rate;
            rnd_q  <= rand_byte;
          end
        end
        S_LOAD: begin
          a_q  <= pa_c;
          lo_q <= (pa_c < pb_c) ? pa_c : pb_c;
          hi_q <= (pa_c < pb_c) ? pb_c : pa_c;
          en_q <= (rnd_q < rate_q);
        end
        S_CROSS: begin
          child1         <= c1_next;
          child2         <= c2_next;
          crossover_done <= 1'b1;
          if (en_q && (mode_q != 2'd3) && (crossover_count != 16'hFFFF)) begin
            crossover_count <= crossover_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crossover.sv
// tb/tb_crossover.sv - directed vector bench for crossover (W=8)
module tb_crossover;

  localparam int W  = 8;
  localparam int PW = 3;

  logic          clk;
  logic          rst_n;
  logic          start_crossover;
  logic [W-1:0]  parent1, parent2, uniform_mask;
  logic [1:0]    crossover_mode;
  logic [PW-1:0] point_a, point_b;
  logic [7:0]    crossover_rate, rand_byte;
  logic [W-1:0]  child1, child2;
  logic          crossover_done;
  logic          busy;
  logic [15:0]   crossover_count;

  crossover #(.CHROMOSOME_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_crossover (start_crossover),
    .parent1         (parent1),
    .parent2         (parent2),
    .crossover_mode  (crossover_mode),
    .point_a         (point_a),
    .point_b         (point_b),
    .uniform_mask    (uniform_mask),
    .crossover_rate  (crossover_rate),
    .rand_byte       (rand_byte),
    .child1          (child1),
    .child2          (child2),
    .crossover_done  (crossover_done),
    .busy            (busy),
    .crossover_count (crossover_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] mode;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] mask;
    logic [7:0] rate;
    logic [7:0] rnd;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       xover;
  } vec_t;

  vec_t        vecs[10];
  int          n_applied = 0;
  int          n_err     = 0;
  logic [15:0] exp_cnt   = 16'h0000;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_applied++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    parent1        = v.p1;
    parent2        = v.p2;
    crossover_mode = v.mode;
    point_a        = v.a;
    point_b        = v.b;
    uniform_mask   = v.mask;
    crossover_rate = v.rate;
    rand_byte      = v.rnd;
  endtask

  // Changes every data input right after the start sample, so a design that
  // does not use its captured copies produces wrong children.
  task automatic scramble(input vec_t v);
    parent1        = ~v.p1;
    parent2        = ~v.p2;
    crossover_mode = v.mode + 2'd1;
    point_a        = v.b;
    point_b        = v.a;
    uniform_mask   = ~v.mask;
    crossover_rate = v.rnd;
    rand_byte      = v.rate;
  endtask

  task automatic model_count(input vec_t v);
    if (v.xover && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    drive(v);
    start_crossover = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_crossover = 1'b0;
    scramble(v);
    lat = 1;
    while (!crossover_done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    model_count(v);
    check({tag, ".latency"}, 16'(lat), 16'd3);
    check({tag, ".child1"}, {8'h00, child1}, {8'h00, v.e1});
    check({tag, ".child2"}, {8'h00, child2}, {8'h00, v.e2});
    check({tag, ".count"}, crossover_count, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int bad;

    //            p1     p2     md    a     b     mask   rate   rnd    e1     e2     x
    vecs[0] = '{8'hFF, 8'h00, 2'd0, 3'd3, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h07, 8'hF8, 1'b1};
    vecs[1] = '{8'hFF, 8'h00, 2'd1, 3'd6, 3'd2, 8'h00, 8'hFF, 8'h00, 8'hC3, 8'h3C, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 2'd2, 3'd0, 3'd0, 8'hAA, 8'hFF, 8'h00, 8'h55, 8'hAA, 1'b1};
    vecs[3] = '{8'h5A, 8'hA5, 2'd0, 3'd3, 3'd0, 8'h00, 8'h10, 8'h10, 8'h5A, 8'hA5, 1'b0};
    vecs[4] = '{8'hF0, 8'h0F, 2'd2, 3'd0, 3'd0, 8'hFF, 8'h00, 8'h00, 8'hF0, 8'h0F, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 2'd3, 3'd2, 3'd5, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 2'd0, 3'd0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 2'd1, 3'd4, 3'd4, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};
    vecs[8] = '{8'hAA, 8'h55, 2'd0, 3'd7, 3'd0, 8'h00, 8'h80, 8'h7F, 8'h2A, 8'hD5, 1'b1};
    vecs[9] = '{8'h00, 8'hFF, 2'd1, 3'd1, 3'd7, 8'h00, 8'hFF, 8'h00, 8'h7E, 8'h81, 1'b1};

    rst_n           = 1'b0;
    start_crossover = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    check("reset.child1", {8'h00, child1}, 16'h0000);
    check("reset.child2", {8'h00, child2}, 16'h0000);
    check("reset.done", {15'h0, crossover_done}, 16'h0000);
    check("reset.busy", {15'h0, busy}, 16'h0000);
    check("reset.count", crossover_count, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start held through LOAD must not launch a second operation.
    @(negedge clk);
    drive(vecs[0]);
    start_crossover = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) check("load_start.busy", {15'h0, busy}, 16'h0001);
      if (n == 2) start_crossover = 1'b0;
      if (crossover_done) ndone++;
    end
    model_count(vecs[0]);
    check("load_start.ndone", 16'(ndone), 16'd1);
    check("load_start.count", crossover_count, exp_cnt);

    // Start held high: one result every third cycle.
    @(negedge clk);
    drive(vecs[1]);
    start_crossover = 1'b1;
    ndone = 0;
    bad = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 10) start_crossover = 1'b0;
      if (crossover_done) begin
        ndone++;
        if (n % 3 != 0) bad++;
      end
    end
    repeat (4) model_count(vecs[1]);
    check("b2b.ndone", 16'(ndone), 16'd4);
    check("b2b.misplaced", 16'(bad), 16'd0);
    check("b2b.child1", {8'h00, child1}, 16'h00C3);
    check("b2b.count", crossover_count, exp_cnt);

    // Saturation from a preloaded count.
    @(negedge clk);
    force dut.crossover_count = 16'hFFFE;
    @(negedge clk);
    release dut.crossover_count;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_op(vecs[0], $sformatf("sat%0d", i));
    end
    check("sat.final", crossover_count, 16'hFFFF);

    // Reset while in CROSS: no done, everything cleared, waits for new start.
    @(negedge clk);
    drive(vecs[2]);
    start_crossover = 1'b1;
    @(negedge clk);
    start_crossover = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.child1", {8'h00, child1}, 16'h0000);
    check("midrst.child2", {8'h00, child2}, 16'h0000);
    check("midrst.done", {15'h0, crossover_done}, 16'h0000);
    check("midrst.busy", {15'h0, busy}, 16'h0000);
    check("midrst.count", crossover_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (crossover_done) ndone++;
    end
    check("midrst.ndone", 16'(ndone), 16'd0);
    check("midrst.idle_busy", {15'h0, busy}, 16'h0000);
    exp_cnt = 16'h0000;
    run_op(vecs[2], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
